// File: rtl/com_event_queue.sv
// Command word qualifier: confirms words that stay stable for STABLE_CNT strobes
// and queues each confirmed change as {changed_mask, new_state} in a FWFT FIFO.
module com_event_queue #(
  parameter int WIDTH      = 16,
  parameter int STABLE_CNT = 8,
  parameter int FIFO_DEPTH = 4,
  parameter logic [WIDTH-1:0] DEFAULT = 16'hFFFF
) (
  input  logic                          clk,
  input  logic                          aclr,
  input  logic [WIDTH-1:0]              in,
  input  logic                          en,
  output logic [WIDTH-1:0]              state,
  output logic [2*WIDTH-1:0]            ev_data,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ovf,
  input  logic                          ovf_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CNT);
  localparam logic [CW-1:0] CONE = CW'(1);
  localparam logic [AW:0]   FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   PONE = (AW + 1)'(1);

  logic [WIDTH-1:0]   cand;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]        wptr;
  logic [AW:0]        rptr;
  logic [AW:0]        level;

  logic confirm;
  logic pop;
  logic full;
  logic wr;
  logic drop;

  always_comb begin
    confirm = (cnt == CMAX) && (cand != state);
    pop     = ev_valid && ev_ready;
    full    = (level == FULL);
    // a pop in the same cycle frees the slot being written
    wr      = confirm && (!full || pop);
    drop    = confirm && full && !pop;
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      cand <= DEFAULT;
      cnt  <= CMAX;
    end else if (en) begin
      if (in != cand) begin
        cand <= in;
        cnt  <= CONE;
      end else if (cnt != CMAX) begin
        cnt <= cnt + CONE;
      end
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state <= DEFAULT;
    end else if (confirm) begin
      state <= cand;
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr) begin
        wptr <= wptr + PONE;
      end
      if (pop) begin
        rptr <= rptr + PONE;
      end
      unique case ({wr, pop})
        2'b10:   level <= level + PONE;
        2'b01:   level <= level - PONE;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wptr[AW-1:0]] <= {cand ^ state, cand};
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  assign ev_valid   = (level != '0);
  assign ev_data    = mem[rptr[AW-1:0]];
  assign fifo_level = level;

endmodule
